// File: rtl/alu_issue_queue.sv
// alu_issue_queue: two-entry issue buffer feeding the ALU, with writeback bypass at
// capture and writeback snooping of buffered source operands.
//   clk, rst                       : clock, synchronous active-high reset
//   i_flush                        : drop every buffered entry
//   i_in_* / o_in_ready            : decode-side handshake and operation fields
//   i_wb_en, i_wb_rd, i_wb_data    : writeback port used for bypass and snoop
//   o_out_* / i_out_ready          : execute-side handshake and head operands
module alu_issue_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [XLEN-1:0] i_in_rs1_val,
    input  logic [XLEN-1:0] i_in_rs2_val,
    input  logic [XLEN-1:0] i_in_imm,
    input  logic            i_in_use_imm,
    input  logic [4:0]      i_in_rs1_addr,
    input  logic [4:0]      i_in_rs2_addr,
    input  logic [4:0]      i_in_alu_op,
    input  logic [4:0]      i_in_rd,
    input  logic            i_wb_en,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_out_a,
    output logic [XLEN-1:0] o_out_b,
    output logic [4:0]      o_out_alu_op,
    output logic [4:0]      o_out_rd
);
    logic [XLEN-1:0] r_a    [DEPTH];
    logic [XLEN-1:0] r_b    [DEPTH];
    logic [4:0]      r_rs1  [DEPTH];
    logic [4:0]      r_rs2  [DEPTH];
    logic            r_breg [DEPTH];
    logic [4:0]      r_op   [DEPTH];
    logic [4:0]      r_rd   [DEPTH];
    logic            r_rp, r_wp;
    logic [1:0]      r_cnt;
    logic            w_push, w_pop, w_hit;
    logic [XLEN-1:0] w_a_in, w_b_in;
    logic [DEPTH-1:0] w_keep;

    assign o_in_ready  = r_cnt != 2'(DEPTH);
    assign o_out_valid = r_cnt != 2'd0;
    assign w_push = i_in_valid && o_in_ready && !i_flush;
    assign w_pop  = o_out_valid && i_out_ready && !i_flush;
    // x0 is hardwired zero, so a writeback to it never forwards
    assign w_hit  = i_wb_en && i_wb_rd != 5'd0;
    assign w_a_in = (w_hit && i_wb_rd == i_in_rs1_addr) ? i_wb_data : i_in_rs1_val;
    assign w_b_in = i_in_use_imm ? i_in_imm :
                    (w_hit && i_wb_rd == i_in_rs2_addr) ? i_wb_data : i_in_rs2_val;

    assign o_out_a      = o_out_valid ? r_a[r_rp]  : '0;
    assign o_out_b      = o_out_valid ? r_b[r_rp]  : '0;
    assign o_out_alu_op = o_out_valid ? r_op[r_rp] : '0;
    assign o_out_rd     = o_out_valid ? r_rd[r_rp] : '0;

    // An entry snoops only while it stays buffered; the head being popped leaves as-is
    always_comb begin
        w_keep = '0;
        for (int i = 0; i < DEPTH; i++)
            w_keep[i] = (r_cnt == 2'd2 || (r_cnt == 2'd1 && r_rp == i[0])) &&
                        !(w_pop && r_rp == i[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_rp  <= 1'b0;
            r_wp  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_a[i]    <= '0;
                r_b[i]    <= '0;
                r_rs1[i]  <= '0;
                r_rs2[i]  <= '0;
                r_breg[i] <= 1'b0;
                r_op[i]   <= '0;
                r_rd[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_keep[i] && w_hit && r_rs1[i] == i_wb_rd) r_a[i] <= i_wb_data;
                if (w_keep[i] && w_hit && r_breg[i] && r_rs2[i] == i_wb_rd) r_b[i] <= i_wb_data;
            end
            // The write slot is always empty when a push is allowed, so no snoop conflict
            if (w_push) begin
                r_a[r_wp]    <= w_a_in;
                r_b[r_wp]    <= w_b_in;
                r_rs1[r_wp]  <= i_in_rs1_addr;
                r_rs2[r_wp]  <= i_in_rs2_addr;
                r_breg[r_wp] <= !i_in_use_imm;
                r_op[r_wp]   <= i_in_alu_op;
                r_rd[r_wp]   <= i_in_rd;
            end
            if (i_flush) begin
                r_cnt <= '0;
                r_rp  <= 1'b0;
                r_wp  <= 1'b0;
            end else begin
                if (w_push) r_wp <= !r_wp;
                if (w_pop) r_rp <= !r_rp;
                r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed and randomized checks of alu_issue_queue against a queue model.
module tb_alu_issue_queue;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, use_imm, wb_en, out_valid, out_ready;
    logic [31:0] rs1_val, rs2_val, imm, wb_data, out_a, out_b;
    logic [4:0]  rs1_addr, rs2_addr, alu_op, rd, wb_rd, out_alu_op, out_rd;
    int          n_chk = 0, n_err = 0;

    typedef struct packed {
        logic [31:0] a, b;
        logic [4:0]  rs1, rs2;
        logic        breg;
        logic [4:0]  op, rd;
    } ent_t;
    ent_t q[$];

    always #5 clk = !clk;

    alu_issue_queue dut (
        .clk(clk), .rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_rs1_val(rs1_val), .i_in_rs2_val(rs2_val), .i_in_imm(imm), .i_in_use_imm(use_imm),
        .i_in_rs1_addr(rs1_addr), .i_in_rs2_addr(rs2_addr), .i_in_alu_op(alu_op), .i_in_rd(rd),
        .i_wb_en(wb_en), .i_wb_rd(wb_rd), .i_wb_data(wb_data), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_out_a(out_a), .o_out_b(out_b), .o_out_alu_op(out_alu_op),
        .o_out_rd(out_rd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic compare_model();
        ent_t h = '0;
        if (q.size() != 0) h = q[0];
        check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        check("in_ready", {31'b0, in_ready}, {31'b0, q.size() != 2});
        check("out_a", out_a, h.a);
        check("out_b", out_b, h.b);
        check("out_alu_op", {27'b0, out_alu_op}, {27'b0, h.op});
        check("out_rd", {27'b0, out_rd}, {27'b0, h.rd});
    endtask

    // Model of one clock edge from the inputs currently applied
    task automatic model_edge();
        bit   hit, pu, po;
        ent_t e;
        if (rst || flush) begin
            q.delete();
            return;
        end
        pu  = in_valid && q.size() < 2;
        po  = out_ready && q.size() > 0;
        hit = wb_en && wb_rd != 0;
        if (po) void'(q.pop_front());
        for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            if (hit && e.rs1 == wb_rd) e.a = wb_data;
            if (hit && e.breg && e.rs2 == wb_rd) e.b = wb_data;
            q[i] = e;
        end
        if (pu) begin
            e.rs1  = rs1_addr;
            e.rs2  = rs2_addr;
            e.breg = !use_imm;
            e.op   = alu_op;
            e.rd   = rd;
            e.a    = (hit && wb_rd == rs1_addr) ? wb_data : rs1_val;
            e.b    = use_imm ? imm : (hit && wb_rd == rs2_addr) ? wb_data : rs2_val;
            q.push_back(e);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle();
        {rst, flush, in_valid, use_imm, wb_en, out_ready} = '0;
        {rs1_val, rs2_val, imm, wb_data} = '0;
        {rs1_addr, rs2_addr, alu_op, rd, wb_rd} = '0;
    endtask

    task automatic op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_op   = o;
        rd       = o + 5'd1;
        rs1_val  = a;
        rs2_val  = b;
        rs1_addr = 5'd10;
        rs2_addr = 5'd11;
        use_imm  = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        cycle();
        rst = 1'b0;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        // single op, visible next cycle, gone the cycle after
        out_ready = 1'b1;
        op(5'd1, 32'd5, 32'd3);
        rd = 5'd7;
        cycle();
        check("single_a", out_a, 32'd5);
        check("single_b", out_b, 32'd3);
        check("single_rd", {27'b0, out_rd}, 32'd7);
        in_valid = 1'b0;
        cycle();
        check("single_gone", {31'b0, out_valid}, 32'd0);
        // backpressure: third op waits for a pop
        out_ready = 1'b0;
        op(5'd0, 32'd1, 32'd2); cycle();
        op(5'd5, 32'd3, 32'd4); cycle();
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        op(5'd8, 32'd5, 32'd6); cycle();
        check("full_head", {27'b0, out_alu_op}, 32'd0);
        out_ready = 1'b1; cycle();
        check("drain1", {27'b0, out_alu_op}, 32'd5);
        out_ready = 1'b0; cycle();
        in_valid = 1'b0; out_ready = 1'b1; cycle();
        check("drain2", {27'b0, out_alu_op}, 32'd8);
        cycle();
        // capture bypass, then x0 never bypasses
        out_ready = 1'b0;
        op(5'd2, 32'd1, 32'd0);
        rs1_addr = 5'd4;
        wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'hDEADBEEF;
        cycle();
        check("bypass_a", out_a, 32'hDEADBEEF);
        in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1; cycle();
        op(5'd2, 32'd1, 32'd0);
        rs1_addr = 5'd0; wb_en = 1'b1; wb_rd = 5'd0; out_ready = 1'b0;
        cycle();
        check("x0_a", out_a, 32'd1);
        in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1; cycle();
        // immediate B immune to snoop, A snooped
        out_ready = 1'b0;
        op(5'd3, 32'd2, 32'd0);
        use_imm = 1'b1; imm = 32'hFFFFFFF0; rs2_addr = 5'd9; rs1_addr = 5'd6;
        cycle();
        in_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h12; cycle();
        check("imm_kept", out_b, 32'hFFFFFFF0);
        wb_rd = 5'd6; wb_data = 32'h77; cycle();
        check("snoop_a", out_a, 32'h77);
        wb_en = 1'b0;
        // flush with two entries buffered and a simultaneous push
        op(5'd4, 32'd9, 32'd9); cycle();
        op(5'd6, 32'd9, 32'd9); flush = 1'b1; cycle();
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_ready", {31'b0, in_ready}, 32'd1);
        flush = 1'b0; in_valid = 1'b0; cycle();
        check("flush_dropped", {31'b0, out_valid}, 32'd0);
        // stream across pointer wrap, reset mid-stream
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op(5'(i + 10), 32'(i), 32'(i * 3));
            cycle();
            check("stream_op", {27'b0, out_alu_op}, 32'(i + 10));
        end
        rst = 1'b1; cycle();
        rst = 1'b0;
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_a", out_a, 32'd0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            flush     = $urandom_range(0, 15) == 0;
            rst       = $urandom_range(0, 63) == 0;
            use_imm   = 1'($urandom);
            wb_en     = 1'($urandom);
            rs1_addr  = 5'($urandom_range(0, 3));
            rs2_addr  = 5'($urandom_range(0, 3));
            wb_rd     = 5'($urandom_range(0, 3));
            alu_op    = 5'($urandom_range(0, 9));
            rd        = 5'($urandom);
            rs1_val   = $urandom;
            rs2_val   = $urandom;
            imm       = $urandom;
            wb_data   = $urandom;
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
